// File: rtl/mul16_wallace_seq_pkg.sv
// Shared types and helpers for the sequential 16x16 multiplier built on one 8x8 Wallace core.
// The step map selects which operand bytes feed the core and how far the partial product is shifted.
package mul16_wallace_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_STEPS = 4;
    localparam int OP_W    = 16;
    localparam int PROD_W  = 32;

    typedef struct packed {
        logic [7:0] a_byte;
        logic [7:0] b_byte;
        logic [4:0] shift;
    } step_sel_t;

    // step[0] picks the high byte of a, step[1] the high byte of b; shift is 8 per high byte.
    function automatic step_sel_t step_map(input logic [1:0] step,
                                           input logic [OP_W-1:0] a,
                                           input logic [OP_W-1:0] b);
        step_sel_t sel;
        sel.a_byte = step[0] ? a[15:8] : a[7:0];
        sel.b_byte = step[1] ? b[15:8] : b[7:0];
        sel.shift  = {step[0] & step[1], step[0] ^ step[1], 3'b000};
        return sel;
    endfunction

endpackage

// File: rtl/mul16_wallace_seq_wallace.sv
// wallace_8x8: 8x8 unsigned carry-save multiplier core. The low 5 product bits are resolved,
// the upper bits leave as a sum/carry pair for the caller's carry-propagate add.
module wallace_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [10:0] sum_hi,
    output logic [10:0] carry_hi,
    output logic [4:0]  sum_lo
);

    function automatic void csa(input  logic [15:0] x,
                                input  logic [15:0] y,
                                input  logic [15:0] z,
                                output logic [15:0] s,
                                output logic [15:0] c);
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [15:0] p [8];
    logic [15:0] s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;
    logic [5:0]  low;
    logic [15:0] fold, hs, hc;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            p[i] = {8'b0, a & {8{b[i]}}} << i;
        end
        csa(p[0], p[1], p[2], s1, c1);
        csa(p[3], p[4], p[5], s2, c2);
        csa(s1, c1, s2, s3, c3);
        csa(c2, p[6], p[7], s4, c4);
        csa(s3, c3, s4, s5, c5);
        csa(s5, c5, c4, s6, c6);
        // Resolve bits [4:0] and fold their carry-out back into the upper carry-save pair.
        low  = {1'b0, s6[4:0]} + {1'b0, c6[4:0]};
        fold = {10'b0, low[5], 5'b0};
        csa(s6 & 16'hFFE0, c6 & 16'hFFE0, fold, hs, hc);
        sum_hi   = hs[15:5];
        carry_hi = hc[15:5];
        sum_lo   = low[4:0];
    end

endmodule

// File: rtl/mul16_wallace_seq.sv
// Multi-cycle 16x16 unsigned multiplier: four byte-pair passes through one wallace_8x8, CPA + accumulate.
// Optional MUL16_ZERO_SKIP_EN: a zero operand bypasses the MUL steps and goes straight to DONE.
module mul16_wallace_seq
    import mul16_wallace_seq_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_prod,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and the source holds its payload until the transfer.

    state_t             state, state_nxt;
    logic [1:0]         step;
    logic [OP_W-1:0]    a_q, b_q;
    logic [TAG_W-1:0]   tag_q;
    logic [PROD_W-1:0]  acc;
    step_sel_t          sel;
    logic [7:0]         w_a, w_b;
    logic [10:0]        w_sum_hi, w_carry_hi;
    logic [4:0]         w_sum_lo;
    logic [15:0]        pp;
    logic               zero_op;

    assign sel = step_map(step, a_q, b_q);
    // Core inputs are held at zero outside MUL so the tree does not toggle while idle.
    assign w_a = (state == MUL) ? sel.a_byte : 8'h00;
    assign w_b = (state == MUL) ? sel.b_byte : 8'h00;

    wallace_8x8 u_wallace (
        .a        (w_a),
        .b        (w_b),
        .sum_hi   (w_sum_hi),
        .carry_hi (w_carry_hi),
        .sum_lo   (w_sum_lo)
    );

    assign pp = ({w_sum_hi, 5'b0} + {w_carry_hi, 5'b0}) | {11'b0, w_sum_lo};

`ifdef MUL16_ZERO_SKIP_EN
    assign zero_op = (in_a == '0) || (in_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = zero_op ? DONE : MUL;
            MUL:     if (step == 2'(N_STEPS - 1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
            acc   <= '0;
            step  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= in_a;
                    b_q   <= in_b;
                    tag_q <= in_tag;
                    acc   <= '0;
                    step  <= '0;
                end
                MUL: begin
                    acc  <= acc + (PROD_W'(pp) << sel.shift);
                    step <= step + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL) || (state == DONE);
    assign out_prod  = acc;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_mul16_wallace_seq.sv
// Directed bench for mul16_wallace_seq: hand-computed products, latency, backpressure and reset cases.
module tb_mul16_wallace_seq;

    localparam int TAG_W = 4;
`ifdef MUL16_ZERO_SKIP_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = 4;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_a, in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_prod;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mul16_wallace_seq #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Counts edges after the acceptance edge until out_valid; bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check_eq("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t,
                         input logic [31:0] prod, input int lat);
        int n;
        logic [31:0] e;
        exp_q.push_back(prod);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 16'($urandom_range(0, 65535));
        in_b = 16'($urandom_range(0, 65535));
        in_tag = TAG_W'($urandom_range(0, 15));
        wait_valid(n);
        check_eq("latency", 32'(n), 32'(lat));
        e = exp_q.pop_front();
        check_eq("prod", out_prod, e);
        check_eq("tag", 32'(out_tag), 32'(t));
        @(posedge clk); #1;
        check_eq("valid_one_cycle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int ov_seen;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

        // Asynchronous reset mid-cycle, before any clock edge
        #3 rst = 1'b1;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_prod", out_prod, 32'd0);
        check_eq("rst_tag", 32'(out_tag), 32'd0);
        @(negedge clk); rst = 1'b0;

        do_op(16'h1234, 16'h5678, 4'h3, 32'h0626_0060, 4);
        do_op(16'hFFFF, 16'hFFFF, 4'hA, 32'hFFFE_0001, 4);
        do_op(16'hFFFF, 16'h0001, 4'h1, 32'h0000_FFFF, 4);
        do_op(16'h0100, 16'h0100, 4'h7, 32'h0001_0000, 4);
        do_op(16'h00FF, 16'hFF00, 4'hC, 32'h00FE_0100, 4);

        // Backpressure with a second request pending
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'h00FF; in_b = 16'h0100; in_tag = 4'h5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        check_eq("bp_latency", 32'(n), 32'd4);
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_tag = 4'h6;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_prod", out_prod, 32'h0000_FF00);
            check_eq("bp_tag", 32'(out_tag), 32'h5);
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_valid", 32'(out_valid), 32'd0);
        check_eq("bp_release_ready", 32'(in_ready), 32'd1);
        check_eq("bp_not_yet_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_eq("bp_second_accepted", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_valid(n);
        check_eq("bp2_latency", 32'(n), 32'd4);
        check_eq("bp2_prod", out_prod, 32'h0000_FFFF);
        check_eq("bp2_tag", 32'(out_tag), 32'h6);
        @(posedge clk); #1;

        // Reset in the middle of an operation
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'h8000; in_b = 16'h8000; in_tag = 4'h9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_tag", 32'(out_tag), 32'd0);
        check_eq("midrst_prod", out_prod, 32'd0);
        @(negedge clk); rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        check_eq("midrst_no_result", 32'(ov_seen), 32'd0);
        do_op(16'h0002, 16'h0003, 4'h2, 32'h0000_0006, 4);

        // Zero operands
        do_op(16'h0000, 16'hABCD, 4'hE, 32'h0000_0000, ZERO_LAT);
        do_op(16'h1234, 16'h0000, 4'hF, 32'h0000_0000, ZERO_LAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
